// File: rtl/median_filter_engine_p.sv
// 3x3 rank-filter engine: fetches each pixel's neighbourhood in raster order,
// ranks the samples with a running insertion sorter and writes median, min or max.
module median_filter_engine_p #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ready_i,
  input  logic [1:0]    mode_i,
  input  logic          pad_mode_i,
  output logic          busy_o,
  output logic [AW-1:0] iaddr_o,
  input  logic [DW-1:0] idata_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_wr_o,
  output logic          wen_o,
  output logic          done_o
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StIns, StWr, StDone} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    k_q, k_d;
  logic [1:0]    mode_q, mode_d;
  logic          pad_q, pad_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic          oob_q, oob_d;
  logic          smp_oob_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wen_q, wen_d;
  logic          done_q, done_d;
  logic [DW-1:0] sort_q [9];
  logic [DW-1:0] sort_d [9];
  logic [DW-1:0] sort_ins [9];
  logic [DW-1:0] smp;
  logic [AW:0]   nb;
  logic          clr, ins;

  // Clamped neighbour address with the out-of-bounds flag in the MSB.
  function automatic logic [AW:0] nb_addr(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                          input logic [3:0] kk);
    int   cx, cy;
    logic oob;
    cx  = int'(px) + (int'(kk) % 3) - 1;
    cy  = int'(py) + (int'(kk) / 3) - 1;
    oob = 1'b0;
    if (cx < 0) begin
      cx  = 0;
      oob = 1'b1;
    end else if (cx > int'(IMG_W) - 1) begin
      cx  = int'(IMG_W) - 1;
      oob = 1'b1;
    end
    if (cy < 0) begin
      cy  = 0;
      oob = 1'b1;
    end else if (cy > int'(IMG_H) - 1) begin
      cy  = int'(IMG_H) - 1;
      oob = 1'b1;
    end
    return {oob, AW'(cy * int'(IMG_W) + cx)};
  endfunction

  // Sample arriving this cycle belongs to the address presented last cycle.
  always_comb begin
    smp = (smp_oob_q && !pad_q) ? '0 : idata_i;
  end

  // Parallel compare-and-shift insertion; empty slots hold all-ones so they sort last.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      if (smp >= sort_q[i]) begin
        sort_ins[i] = sort_q[i];
      end else if (i == 0) begin
        sort_ins[i] = smp;
      end else if (smp >= sort_q[i-1]) begin
        sort_ins[i] = smp;
      end else begin
        sort_ins[i] = sort_q[i-1];
      end
    end
  end

  // Sorter next state: clear at pixel start, insert while samples stream in.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      if (clr) begin
        sort_d[i] = {DW{1'b1}};
      end else if (ins) begin
        sort_d[i] = sort_ins[i];
      end else begin
        sort_d[i] = sort_q[i];
      end
    end
  end

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    mode_d  = mode_q;
    pad_d   = pad_q;
    busy_d  = busy_q;
    iaddr_d = iaddr_q;
    oob_d   = oob_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    clr     = 1'b0;
    ins     = 1'b0;
    nb      = '0;
    unique case (state_q)
      StIdle: begin
        if (ready_i) begin
          state_d = StFetch;
          busy_d  = 1'b1;
          mode_d  = mode_i;
          pad_d   = pad_mode_i;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          clr     = 1'b1;
          nb      = nb_addr('0, '0, 4'd0);
          iaddr_d = nb[AW-1:0];
          oob_d   = nb[AW];
        end
      end
      StFetch: begin
        ins = (k_q != 4'd0);
        if (k_q == 4'd8) begin
          state_d = StIns;
        end else begin
          k_d     = k_q + 4'd1;
          nb      = nb_addr(x_q, y_q, k_q + 4'd1);
          iaddr_d = nb[AW-1:0];
          oob_d   = nb[AW];
        end
      end
      StIns: begin
        ins     = 1'b1;
        state_d = StWr;
        wen_d   = 1'b1;
        addr_d  = AW'(int'(y_q) * int'(IMG_W) + int'(x_q));
        case (mode_q)
          2'b01:   data_d = sort_ins[0];
          2'b10:   data_d = sort_ins[8];
          default: data_d = sort_ins[4];
        endcase
      end
      StWr: begin
        if (int'(x_q) == int'(IMG_W) - 1 && int'(y_q) == int'(IMG_H) - 1) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (int'(x_q) == int'(IMG_W) - 1) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          state_d = StFetch;
          k_d     = '0;
          clr     = 1'b1;
          nb      = nb_addr(x_d, y_d, 4'd0);
          iaddr_d = nb[AW-1:0];
          oob_d   = nb[AW];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      mode_q    <= '0;
      pad_q     <= 1'b0;
      busy_q    <= 1'b0;
      iaddr_q   <= '0;
      oob_q     <= 1'b0;
      smp_oob_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 9; i++) sort_q[i] <= {DW{1'b1}};
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      mode_q    <= mode_d;
      pad_q     <= pad_d;
      busy_q    <= busy_d;
      iaddr_q   <= iaddr_d;
      oob_q     <= oob_d;
      smp_oob_q <= oob_q;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      done_q    <= done_d;
      for (int i = 0; i < 9; i++) sort_q[i] <= sort_d[i];
    end
  end

  assign busy_o    = busy_q;
  assign iaddr_o   = iaddr_q;
  assign addr_o    = addr_q;
  assign data_wr_o = data_q;
  assign wen_o     = wen_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_median_filter_engine_p.sv
// Scoreboard bench for a 4x4 instance of median_filter_engine_p.
module tb_median_filter_engine_p;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [1:0] mode;
  logic       pad;
  logic       busy;
  logic [3:0] iaddr;
  logic [7:0] idata;
  logic [3:0] addr;
  logic [7:0] data_wr;
  logic       wen;
  logic       done;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] img [W*H];
  logic [7:0] got [W*H];
  int         checks;
  int         errors;

  median_filter_engine_p #(
    .IMG_W(W),
    .IMG_H(H),
    .DW   (8),
    .AW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready_i   (ready),
    .mode_i    (mode),
    .pad_mode_i(pad),
    .busy_o    (busy),
    .iaddr_o   (iaddr),
    .idata_i   (idata),
    .addr_o    (addr),
    .data_wr_o (data_wr),
    .wen_o     (wen),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory with one-cycle read latency.
  always @(posedge clk) idata <= img[iaddr];

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wen && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h, required no write", addr, data_wr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (addr !== e.a || data_wr !== e.d) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   addr, data_wr, e.a, e.d);
        end
        got[addr] = data_wr;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: gather neighbourhood, bubble sort, pick rank.
  function automatic logic [7:0] model(input int x, input int y, input logic [1:0] m,
                                       input logic p);
    logic [7:0] v [9];
    logic [7:0] t;
    int         cx, cy;
    bit         oob;
    for (int k = 0; k < 9; k++) begin
      cx  = x + k % 3 - 1;
      cy  = y + k / 3 - 1;
      oob = (cx < 0) || (cx > W - 1) || (cy < 0) || (cy > H - 1);
      if (cx < 0) cx = 0;
      if (cx > W - 1) cx = W - 1;
      if (cy < 0) cy = 0;
      if (cy > H - 1) cy = H - 1;
      v[k] = (oob && !p) ? 8'd0 : img[cy * W + cx];
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t      = v[j];
          v[j]   = v[j+1];
          v[j+1] = t;
        end
      end
    end
    case (m)
      2'b01:   return v[0];
      2'b10:   return v[8];
      default: return v[4];
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] m, input logic p);
    wr_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.a = 4'(y * W + x);
        e.d = model(x, y, m, p);
        exp_q.push_back(e);
      end
    end
  endtask

  // Run one full frame; optionally toggle ready while busy and check pixel-0 timing.
  task automatic run_frame(input logic [1:0] m, input logic p, input bit toggle,
                           input bit timing);
    int         nbusy, ndone, donei, first_wen;
    logic [3:0] iseq [9];
    int         req_seq [9];
    req_seq = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
    nbusy = 0;
    ndone = 0;
    donei = 0;
    first_wen = -1;
    push_frame(m, p);
    @(negedge clk);
    ready = 1'b1;
    mode  = m;
    pad   = p;
    @(negedge clk);
    ready = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      if (i <= 9) iseq[i-1] = iaddr;
      if (busy) nbusy++;
      if (wen && first_wen < 0) first_wen = i;
      if (done) begin
        ndone++;
        donei = i;
      end
      if (toggle) ready = busy && (i % 2 == 0);
      if (ndone > 0 && i >= donei + 2) break;
      @(negedge clk);
    end
    ready = 1'b0;
    chk("busy_cycles", nbusy, 176);
    chk("done_pulses", ndone, 1);
    chk("done_cycle", donei, 177);
    chk("first_wen_cycle", first_wen, 11);
    chk("scoreboard_drained", exp_q.size(), 0);
    if (timing) begin
      for (int k = 0; k < 9; k++) chk($sformatf("iaddr_k%0d", k), int'(iseq[k]), req_seq[k]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ready  = 1'b0;
    mode   = 2'b00;
    pad    = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < W * H; i++) img[i] = 8'h5A;
    #1;
    chk("reset_outputs", int'({busy, iaddr, addr, data_wr, wen, done}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Constant image, median, replicate; includes pixel-0 address sequence.
    run_frame(2'b00, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < W * H; i++) img[i] = 8'(i);
    run_frame(2'b00, 1'b1, 1'b0, 1'b0);
    chk("ramp_med_rep_a0", got[0], 1);
    chk("ramp_med_rep_a5", got[5], 5);
    chk("ramp_med_rep_a15", got[15], 14);
    run_frame(2'b01, 1'b1, 1'b0, 1'b0);
    chk("ramp_min_rep_a0", got[0], 0);
    chk("ramp_min_rep_a5", got[5], 0);
    run_frame(2'b10, 1'b1, 1'b0, 1'b0);
    chk("ramp_max_rep_a0", got[0], 5);
    chk("ramp_max_rep_a5", got[5], 10);
    run_frame(2'b00, 1'b0, 1'b0, 1'b1);
    chk("ramp_med_zero_a0", got[0], 0);
    chk("ramp_med_zero_a1", got[1], 1);
    chk("ramp_med_zero_a5", got[5], 5);

    // Reserved mode behaves as median; ready toggling while busy must be ignored.
    run_frame(2'b11, 1'b0, 1'b1, 1'b0);

    // Abort during the third pixel.
    push_frame(2'b10, 1'b1);
    @(negedge clk);
    ready = 1'b1;
    mode  = 2'b10;
    pad   = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_outputs", int'({busy, iaddr, addr, data_wr, wen, done}), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    begin
      int nwen;
      nwen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (wen || busy) nwen++;
      end
      chk("no_activity_after_abort", nwen, 0);
    end

    // Restart with a pseudo-random image.
    for (int i = 0; i < W * H; i++) img[i] = 8'($urandom_range(0, 255));
    run_frame(2'b00, 1'b0, 1'b0, 1'b0);
    run_frame(2'b01, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
